// File: rtl/ahb_input_stage_phy.sv
// ahb_input_stage_phy
// Master-side input stage of the bus matrix. Turns a master address phase
// into a request toward the output arbiter and holds that address phase
// until the port is granted. The master is stretched while it waits, and the
// output stage's data-phase response is returned to it.
module ahb_input_stage_phy #(
  parameter int ADDR_W = 32,
  parameter int PROT_W = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  // Master side
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [PROT_W-1:0] HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  // Arbiter side
  output logic              req_port,
  input  logic              grant,
  // Output-stage side
  output logic              HSELM,
  output logic [ADDR_W-1:0] HADDRM,
  output logic [1:0]        HTRANSM,
  output logic              HWRITEM,
  output logic [2:0]        HSIZEM,
  output logic [2:0]        HBURSTM,
  output logic [PROT_W-1:0] HPROTM,
  output logic              HMASTLOCKM,
  input  logic              HREADYM,
  input  logic              HRESPM
);

  localparam logic [1:0] TRANS_IDLE = 2'b00;

  typedef struct packed {
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [PROT_W-1:0] prot;
    logic              lock;
  } addr_ph_t;

  addr_ph_t live_ph;
  addr_ph_t held_ph;
  addr_ph_t out_ph;

  logic pend;
  logic data_ph;
  logic valid_in;
  logic capture;
  logic accept;
  logic cancel;

  // Bundle the live master address phase.
  always_comb begin
    live_ph       = '0;
    live_ph.sel   = HSELS;
    live_ph.addr  = HADDRS;
    live_ph.trans = HTRANSS;
    live_ph.write = HWRITES;
    live_ph.size  = HSIZES;
    live_ph.burst = HBURSTS;
    live_ph.prot  = HPROTS;
    live_ph.lock  = HMASTLOCKS;
  end

  // Only NONSEQ/SEQ become requests; IDLE/BUSY are answered locally.
  assign valid_in = HSELS & HREADYS & HTRANSS[1];
  assign capture  = HSELS & HREADYS;
  assign accept   = grant & HREADYM;
  // An IDLE issued after an ERROR response drops any beat still waiting.
  assign cancel   = (HTRANSS == TRANS_IDLE) & data_ph & HRESPM;

  assign req_port = pend | valid_in;

  // Held phase takes over the output-stage bus while waiting for grant.
  always_comb begin
    out_ph = pend ? held_ph : live_ph;
  end

  // Holding register, pending-request and data-phase tracking.
  always_ff @(posedge HCLK) begin
    // NOTE: the holding register is reset along with the flags so the held
    // address phase is known-zero after reset; state uses non-blocking
    // assignments throughout so every flag sees pre-edge values.
    if (HRESET) begin
      pend    <= 1'b0;
      data_ph <= 1'b0;
      held_ph <= '0;
    end else begin
      if (capture) held_ph <= live_ph;

      if (accept)        pend <= 1'b0;
      else if (valid_in) pend <= 1'b1;
      else if (cancel)   pend <= 1'b0;

      if (accept & req_port & out_ph.trans[1]) data_ph <= 1'b1;
      else if (HREADYM)                        data_ph <= 1'b0;
    end
  end

  assign HSELM      = out_ph.sel;
  assign HADDRM     = out_ph.addr;
  assign HTRANSM    = (req_port | data_ph) ? out_ph.trans : TRANS_IDLE;
  assign HWRITEM    = out_ph.write;
  assign HSIZEM     = out_ph.size;
  assign HBURSTM    = out_ph.burst;
  assign HPROTM     = out_ph.prot;
  assign HMASTLOCKM = out_ph.lock;

  assign HREADYOUTS = pend ? 1'b0 : (data_ph ? HREADYM : 1'b1);
  assign HRESPS     = data_ph ? HRESPM : 1'b0;

endmodule
